input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent asynchronous inputs, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel, minimum 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 60000: consecutive stable cycles required to accept a change (1 ms at 60 MHz); 0 permitted.
REQ-004 Parameter RESET_HOLD, default 4: clock cycles reset_out stays high after reset deasserts, minimum 1.
REQ-005 Parameter INIT_LEVEL, default all-zero CHANNELS-bit vector: per-channel level loaded at reset.
REQ-006 Port clock, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1: reset, asynchronous and active-high.
REQ-008 Port raw_in, input, CHANNELS: unsynchronized buttons, switches or UART control lines.
REQ-009 Port level_out, output, CHANNELS: synchronized, debounced level per channel.
REQ-010 Port rise_pulse, output, CHANNELS: one-cycle strobe on an accepted 0->1 change.
REQ-011 Port fall_pulse, output, CHANNELS: one-cycle strobe on an accepted 1->0 change.
REQ-012 Port reset_out, output, 1: conditioned reset for downstream logic; asserts asynchronously, deasserts synchronously.

Function
REQ-013 Each channel SHALL pass raw_in through a SYNC_STAGES-deep flop chain; only the last stage (sync_q) SHALL feed later logic.
REQ-014 Each channel SHALL have a debounce counter of width clog2(DEBOUNCE_CYCLES+1), minimum 1 bit.
REQ-015 On an edge where sync_q equals level_out, the counter SHALL clear to 0.
REQ-016 On an edge where sync_q differs from level_out and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-017 On an edge where sync_q differs and counter >= DEBOUNCE_CYCLES-1, level_out SHALL take sync_q and the counter SHALL clear.
  - This rule is what makes DEBOUNCE_CYCLES 0 and 1 behave identically.
REQ-018 Latency: define edge 1 as the first edge that samples a new raw value; level_out SHALL change at edge SYNC_STAGES+max(DEBOUNCE_CYCLES,1), provided raw stays stable.
REQ-019 A mismatch shorter than max(DEBOUNCE_CYCLES,1) consecutive sync_q cycles SHALL not change level_out and SHALL produce no pulse.
REQ-020 rise_pulse[i] and fall_pulse[i] SHALL be registered and high only in the cycle level_out[i] first shows its new value; they SHALL never both be high.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 The counter SHALL never exceed DEBOUNCE_CYCLES and SHALL not wrap.
REQ-023 reset_out SHALL be driven by a RESET_HOLD-deep shift register clocked by clock, asynchronously set by reset, shifting in 0.
REQ-024 reset_out SHALL go low on the RESET_HOLD-th rising edge after reset deasserts.

Reset
REQ-025 While reset is high, the outputs SHALL hold these values:
  - every synchronizer stage = INIT_LEVEL
  - level_out = INIT_LEVEL
  - counters = 0
  - rise_pulse = 0 and fall_pulse = 0
  - reset_out = 1
REQ-026 These values SHALL be reached asynchronously, without a clock edge.
REQ-027 Reset asserted mid-debounce SHALL discard the count; no pulse SHALL be emitted on entry to or exit from reset.
REQ-028 After reset release, a raw_in that differs from INIT_LEVEL SHALL be treated as a normal change: full latency, then one pulse.

Verification (CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_HOLD=3, INIT_LEVEL=2'b00 unless noted)
REQ-029 Reset pulse, then release between edges -> reset_out stays 1 through edges 1-2 and is 0 after edge 3; level_out=00; no pulses.
REQ-030 raw_in[0] steps 0->1 and holds -> level_out[0]=1 after edge 6; rise_pulse[0]=1 for that cycle only; fall_pulse stays 0.
REQ-031 raw_in[1] high for 3 cycles, then low -> level_out[1] stays 0; no pulses; counter back to 0.
REQ-032 From level_out=01, raw_in changes 01->10 on the same edge -> after edge 6, fall_pulse=01 and rise_pulse=10 in the same cycle; level_out=10.
REQ-033 Reset asserted while a channel counter=2 -> all outputs take reset values immediately; after release, no pulse until a new change is fully debounced.
REQ-034 Rebuild with DEBOUNCE_CYCLES=0 and INIT_LEVEL=2'b11, then apply raw_in 11->01 -> fall_pulse[1] at edge 3; counter width 1; no other pulses.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer, debouncer and edge strobes, plus a conditioned reset
module input_conditioner #(
  parameter int CHANNELS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int RESET_HOLD = 4,
  parameter logic [CHANNELS-1:0] INIT_LEVEL = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                reset_out
);
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // Accept once the count reaches DEBOUNCE_CYCLES-1, so 0 and 1 both mean a single-cycle filter
  localparam logic [CW-1:0] LIM = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  logic [RESET_HOLD-1:0] hold_r;
  // Reset stretcher: set asynchronously, drains one zero per clock after release
  always_ff @(posedge clock or posedge reset)
    if (reset) hold_r <= '1;
    else hold_r <= hold_r << 1;
  assign reset_out = hold_r[RESET_HOLD-1];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0] cnt;
    logic level_q, rise_q, fall_q, sync_q, diff, accept;
    assign sync_q = sync_r[SYNC_STAGES-1];
    assign diff = sync_q ^ level_q;
    assign accept = diff && (cnt >= LIM);
    // Synchronize, count consecutive mismatch cycles, commit the new level and strobe on acceptance
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        sync_r <= {SYNC_STAGES{INIT_LEVEL[c]}};
        cnt <= '0;
        level_q <= INIT_LEVEL[c];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in[c]};
        cnt <= (diff && !accept) ? cnt + 1'b1 : '0;
        level_q <= accept ? sync_q : level_q;
        rise_q <= accept && sync_q;
        fall_q <= accept && !sync_q;
      end
    assign level_out[c] = level_q;
    assign rise_pulse[c] = rise_q;
    assign fall_pulse[c] = fall_q;
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table-driven and directed checks of input_conditioner
module tb_input_conditioner;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] raw_in, raw_b;
  logic [1:0] level_out, rise_pulse, fall_pulse, level_b, rise_b, fall_b;
  logic reset_out, reset_out_b;
  int passed = 0;
  int total = 0;

  always #5 clock = ~clock;

  input_conditioner #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_HOLD(3), .INIT_LEVEL(2'b00)) u_dut (
    .clock(clock), .reset(reset), .raw_in(raw_in), .level_out(level_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .reset_out(reset_out));

  input_conditioner #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .RESET_HOLD(3), .INIT_LEVEL(2'b11)) u_dut0 (
    .clock(clock), .reset(reset), .raw_in(raw_b), .level_out(level_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .reset_out(reset_out_b));

  typedef struct {
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
    logic ro;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic edge_wait();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_main(input string n, input logic [1:0] l, input logic [1:0] r, input logic [1:0] f);
    chk({n, " level"}, 32'(level_out), 32'(l));
    chk({n, " rise"}, 32'(rise_pulse), 32'(r));
    chk({n, " fall"}, 32'(fall_pulse), 32'(f));
  endtask

  task automatic chk_b(input string n, input logic [1:0] l, input logic [1:0] r, input logic [1:0] f);
    chk({n, " level_b"}, 32'(level_b), 32'(l));
    chk({n, " rise_b"}, 32'(rise_b), 32'(r));
    chk({n, " fall_b"}, 32'(fall_b), 32'(f));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tbl[i] = '{2'b00, 2'b00, 2'b00, 2'b00, (i < 2) ? 1'b1 : 1'b0};
    for (int i = 3; i < 8; i++) tbl[i] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[8] = '{2'b01, 2'b01, 2'b01, 2'b00, 1'b0};
    tbl[9] = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    for (int i = 10; i < 13; i++) tbl[i] = '{2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
    for (int i = 13; i < 17; i++) tbl[i] = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    for (int i = 17; i < 22; i++) tbl[i] = '{2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    tbl[22] = '{2'b10, 2'b10, 2'b10, 2'b01, 1'b0};
    tbl[23] = '{2'b10, 2'b10, 2'b00, 2'b00, 1'b0};

    reset = 1'b1;
    raw_in = 2'b00;
    raw_b = 2'b11;
    #1;
    chk_main("por", 2'b00, 2'b00, 2'b00);
    chk("por reset_out", 32'(reset_out), 32'd1);
    chk_b("por", 2'b11, 2'b00, 2'b00);
    edge_wait();
    edge_wait();
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      raw_in = tbl[i].raw;
      edge_wait();
      chk_main($sformatf("row%0d", i), tbl[i].lvl, tbl[i].rise, tbl[i].fall);
      chk($sformatf("row%0d reset_out", i), 32'(reset_out), 32'(tbl[i].ro));
      if (i == 16) chk("glitch cnt1 cleared", 32'(u_dut.g_ch[1].cnt), 32'd0);
    end

    raw_in = 2'b01;
    repeat (4) edge_wait();
    chk("mid cnt0", 32'(u_dut.g_ch[0].cnt), 32'd2);
    chk_main("mid", 2'b10, 2'b00, 2'b00);
    reset = 1'b1;
    #1;
    chk_main("async rst", 2'b00, 2'b00, 2'b00);
    chk("async rst reset_out", 32'(reset_out), 32'd1);
    chk("async rst cnt0", 32'(u_dut.g_ch[0].cnt), 32'd0);
    chk_b("async rst", 2'b11, 2'b00, 2'b00);
    #2;
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      edge_wait();
      chk_main($sformatf("post rst e%0d", e), (e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00);
      if (e == 2 || e == 3) chk($sformatf("post rst e%0d reset_out", e), 32'(reset_out), (e == 2) ? 32'd1 : 32'd0);
    end
    chk_b("b idle", 2'b11, 2'b00, 2'b00);

    raw_b = 2'b01;
    for (int e = 1; e <= 4; e++) begin
      edge_wait();
      chk_b($sformatf("db0 e%0d", e), (e >= 3) ? 2'b01 : 2'b11, 2'b00, (e == 3) ? 2'b10 : 2'b00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
